// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for ripple-ALU initiators: op codes, controller states and
// the op -> {op1,op2,sub,cin} control decode.
package alu_issue_ctrl_pkg;

  localparam int ALU_W      = 32;
  localparam int ALU_SETTLE = 4;

  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  typedef struct packed {
    logic op1;
    logic op2;
    logic sub;
    logic cin;
  } alu_ctl_t;

  function automatic logic alu_op_legal(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  // SUB is a + ~b + 1, so it sets both sub and cin.
  function automatic alu_ctl_t alu_decode(input logic [2:0] op);
    alu_ctl_t c;
    c = '0;
    case (op)
      ALU_OR:  c.op1 = 1'b1;
      ALU_ADD: c.op2 = 1'b1;
      ALU_SUB: begin
        c.op2 = 1'b1;
        c.sub = 1'b1;
        c.cin = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request, response and ALU-drive bundle of the ripple ALU issue controller.
// Both req and rsp are valid/ready: a transfer happens on a rising edge where
// valid && ready; valid and its payload stay stable until that edge.
interface alu_issue_ctrl_if #(parameter int W = 32);
  logic         req_valid;
  logic         req_ready;
  logic [2:0]   req_op;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;

  logic [W:0]   alu_a;
  logic [W:0]   alu_b;
  logic         alu_cin;
  logic [W:0]   alu_op1;
  logic [W:0]   alu_op2;
  logic [W:0]   alu_sub;
  logic [W:0]   alu_out;
  logic         alu_cout;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic         rsp_zero;
  logic         rsp_carry;
  logic         rsp_ovf;
  logic         rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready, alu_out, alu_cout,
    input  req_ready, alu_a, alu_b, alu_cin, alu_op1, alu_op2, alu_sub,
    input  rsp_valid, rsp_data, rsp_zero, rsp_carry, rsp_ovf, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready, alu_out, alu_cout,
    output req_ready, alu_a, alu_b, alu_cin, alu_op1, alu_op2, alu_sub,
    output rsp_valid, rsp_data, rsp_zero, rsp_carry, rsp_ovf, rsp_err
  );
endinterface

// File: rtl/alu_flag_gen.sv
// Zero/carry/overflow flags for a settled ALU result; carry and overflow only
// have meaning for ADD/SUB.
module alu_flag_gen
  import alu_issue_ctrl_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [2:0]   i_op,
  input  logic         i_a_msb,
  input  logic         i_b_msb,
  input  logic [W-1:0] i_res,
  input  logic         i_cout,
  output logic         o_zero,
  output logic         o_carry,
  output logic         o_ovf
);
  logic w_is_add;
  logic w_is_sub;
  logic w_res_flip;

  assign w_is_add   = (i_op == ALU_ADD);
  assign w_is_sub   = (i_op == ALU_SUB);
  assign w_res_flip = (i_res[W-1] != i_a_msb);

  assign o_zero  = (i_res == '0);
  assign o_carry = (w_is_add || w_is_sub) && i_cout;
  // SUB overflows only when the operand signs differ, ADD only when they match.
  assign o_ovf   = (w_is_add && (i_a_msb == i_b_msb) && w_res_flip) ||
                   (w_is_sub && (i_a_msb != i_b_msb) && w_res_flip);
endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one (op,a,b) to the combinational ripple ALU, holds the drives for
// SETTLE cycles, then captures result and flags for the response channel.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int W      = ALU_W,
  parameter int SETTLE = ALU_SETTLE
) (
  input  logic           clk,
  input  logic           rst,
  alu_issue_ctrl_if.slave bus,
  output state_e         o_dbg_state
);
  localparam int CW = $clog2(SETTLE + 1);

  state_e       r_state;
  state_e       w_state_nxt;
  logic [2:0]   r_op;
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic [W-1:0] r_data;
  logic [CW-1:0] r_cnt;
  logic         r_drv_on;
  logic         r_zero;
  logic         r_carry;
  logic         r_ovf;
  logic         r_err;

  logic         w_accept;
  logic         w_legal;
  logic         w_capture;
  logic         w_rsp_done;
  logic         w_zero;
  logic         w_carry;
  logic         w_ovf;
  alu_ctl_t     w_ctl;

  assign w_accept   = (r_state == ST_IDLE) && bus.req_valid;
  assign w_legal    = alu_op_legal(bus.req_op);
  assign w_capture  = (r_state == ST_DRIVE) && r_drv_on && (r_cnt == '0);
  assign w_rsp_done = (r_state == ST_RESP) && bus.rsp_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept)   w_state_nxt = w_legal ? ST_DRIVE : ST_RESP;
      ST_DRIVE: if (w_capture)  w_state_nxt = ST_RESP;
      ST_RESP:  if (w_rsp_done) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  alu_flag_gen #(.W(W)) u_flag_gen (
    .i_op    (r_op),
    .i_a_msb (r_a[W-1]),
    .i_b_msb (r_b[W-1]),
    .i_res   (bus.alu_out[W-1:0]),
    .i_cout  (bus.alu_cout),
    .o_zero  (w_zero),
    .o_carry (w_carry),
    .o_ovf   (w_ovf)
  );

  // The first DRIVE cycle only turns the drives on; the counter then spans
  // SETTLE held cycles, giving accept-to-response latency of SETTLE+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_data   <= '0;
      r_cnt    <= '0;
      r_drv_on <= 1'b0;
      r_zero   <= 1'b0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op     <= bus.req_op;
        r_a      <= bus.req_a;
        r_b      <= bus.req_b;
        r_cnt    <= CW'(SETTLE - 1);
        r_drv_on <= 1'b0;
        r_data   <= '0;
        r_zero   <= 1'b0;
        r_carry  <= 1'b0;
        r_ovf    <= 1'b0;
        r_err    <= ~w_legal;
      end
      if (r_state == ST_DRIVE) begin
        if (!r_drv_on) begin
          r_drv_on <= 1'b1;
        end else if (w_capture) begin
          r_data  <= bus.alu_out[W-1:0];
          r_zero  <= w_zero;
          r_carry <= w_carry;
          r_ovf   <= w_ovf;
        end else begin
          r_cnt <= r_cnt - CW'(1);
        end
      end
      if (w_rsp_done) begin
        r_drv_on <= 1'b0;
        r_data   <= '0;
        r_zero   <= 1'b0;
        r_carry  <= 1'b0;
        r_ovf    <= 1'b0;
        r_err    <= 1'b0;
      end
    end
  end

  assign w_ctl = r_drv_on ? alu_decode(r_op) : '0;

  assign bus.alu_a   = r_drv_on ? {1'b0, r_a} : '0;
  assign bus.alu_b   = r_drv_on ? {1'b0, r_b} : '0;
  assign bus.alu_cin = w_ctl.cin;
  assign bus.alu_op1 = {(W+1){w_ctl.op1}};
  assign bus.alu_op2 = {(W+1){w_ctl.op2}};
  assign bus.alu_sub = {(W+1){w_ctl.sub}};

  assign bus.req_ready = (r_state == ST_IDLE);
  assign bus.rsp_valid = (r_state == ST_RESP);
  assign bus.rsp_data  = r_data;
  assign bus.rsp_zero  = r_zero;
  assign bus.rsp_carry = r_carry;
  assign bus.rsp_ovf   = r_ovf;
  assign bus.rsp_err   = r_err;

  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl driving a behavioural ripple ALU whose
// output is only correct once its inputs have been held SETTLE cycles.
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

  localparam int W      = 32;
  localparam int SETTLE = 4;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_e dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  alu_issue_ctrl_if #(.W(W)) bus ();

  alu_issue_ctrl #(.W(W), .SETTLE(SETTLE)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- ALU model ----------------
  logic [5*(W+1):0] alu_in;
  logic [5*(W+1):0] alu_in_prev = '0;
  logic [W:0]       alu_sum;
  logic [W-1:0]     alu_res;
  int               hold_cyc = 0;

  always_comb begin
    alu_in  = {bus.alu_a, bus.alu_b, bus.alu_op1, bus.alu_op2, bus.alu_sub, bus.alu_cin};
    alu_sum = {1'b0, bus.alu_a[W-1:0]} + {1'b0, bus.alu_b[W-1:0] ^ {W{bus.alu_sub[0]}}}
              + {{W{1'b0}}, bus.alu_cin};
    if (bus.alu_op2[0])      alu_res = alu_sum[W-1:0];
    else if (bus.alu_op1[0]) alu_res = bus.alu_a[W-1:0] | bus.alu_b[W-1:0];
    else                     alu_res = bus.alu_a[W-1:0] & bus.alu_b[W-1:0];
    if (hold_cyc >= SETTLE) begin
      bus.alu_out  = {1'b0, alu_res};
      bus.alu_cout = alu_sum[W];
    end else begin
      bus.alu_out  = {1'b0, alu_res ^ 32'h5a5a_a5a5};
      bus.alu_cout = ~alu_sum[W];
    end
  end

  always @(negedge clk) begin
    if (alu_in == alu_in_prev) begin
      if (hold_cyc < 1000) hold_cyc = hold_cyc + 1;
    end else begin
      hold_cyc = 1;
    end
    alu_in_prev = alu_in;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input string tag, input logic [2:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] e_data, input logic e_zero,
                        input logic e_carry, input logic e_ovf, input logic e_err,
                        input logic e_cin, input int e_lat, input int hold,
                        input bit early_ready);
    int n;
    int lat;
    logic [W-1:0] e;
    logic [W:0]   e_alu_a;
    e_alu_a = e_err ? '0 : {1'b0, a};
    exp_q.push_back(e_data);
    bus.rsp_ready = early_ready;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_req_ready"}, 64'(bus.req_ready), 64'd1);
    tick();
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    lat = 0;
    while (!bus.rsp_valid && lat < 3*SETTLE + 10) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(e_lat));
    e = exp_q.pop_front();
    check({tag, "_data"},  64'(bus.rsp_data),  64'(e));
    check({tag, "_zero"},  64'(bus.rsp_zero),  64'(e_zero));
    check({tag, "_carry"}, 64'(bus.rsp_carry), 64'(e_carry));
    check({tag, "_ovf"},   64'(bus.rsp_ovf),   64'(e_ovf));
    check({tag, "_err"},   64'(bus.rsp_err),   64'(e_err));
    check({tag, "_alu_a"}, 64'(bus.alu_a),     64'(e_alu_a));
    check({tag, "_cin"},   64'(bus.alu_cin),   64'(e_cin));
    if (!early_ready) begin
      for (int i = 0; i < hold; i++) begin
        tick();
        check({tag, "_hold_valid"}, 64'(bus.rsp_valid), 64'd1);
        check({tag, "_hold_data"},  64'(bus.rsp_data),  64'(e));
        check({tag, "_hold_err"},   64'(bus.rsp_err),   64'(e_err));
        check({tag, "_hold_alu_a"}, 64'(bus.alu_a),     64'(e_alu_a));
      end
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check({tag, "_done_valid"}, 64'(bus.rsp_valid), 64'd0);
    check({tag, "_done_ready"}, 64'(bus.req_ready), 64'd1);
    check({tag, "_done_alu_a"}, 64'(bus.alu_a),     64'd0);
    check({tag, "_done_op2"},   64'(bus.alu_op2),   64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int seen_rsp;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_data",  64'(bus.rsp_data),  64'd0);
    check("rst_flags",     64'({bus.rsp_zero, bus.rsp_carry, bus.rsp_ovf, bus.rsp_err}), 64'd0);
    check("rst_alu_drv",   64'({bus.alu_a, bus.alu_op1, bus.alu_op2, bus.alu_sub, bus.alu_cin}), 64'd0);
    check("rst_state",     64'(dbg_state), 64'(ST_IDLE));

    //      tag         op       a             b             data          z  c  o  e  cin lat       hold early
    do_req("add40",    ALU_ADD, 32'd40,       32'd10,       32'd50,       0, 0, 0, 0, 0, SETTLE+1, 0, 0);
    do_req("sub40",    ALU_SUB, 32'd40,       32'd10,       32'd30,       0, 1, 0, 0, 1, SETTLE+1, 0, 0);
    do_req("sub10",    ALU_SUB, 32'd10,       32'd40,       32'hFFFFFFE2, 0, 0, 0, 0, 1, SETTLE+1, 0, 0);
    do_req("sub_eq",   ALU_SUB, 32'd7,        32'd7,        32'd0,        1, 1, 0, 0, 1, SETTLE+1, 0, 0);
    do_req("add_ovf",  ALU_ADD, 32'h7FFFFFFF, 32'd1,        32'h80000000, 0, 0, 1, 0, 0, SETTLE+1, 0, 0);
    do_req("add_wrap", ALU_ADD, 32'hFFFFFFFF, 32'd1,        32'd0,        1, 1, 0, 0, 0, SETTLE+1, 0, 0);
    do_req("and",      ALU_AND, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 0, 0, 0, 0, 0, SETTLE+1, 2, 0);
    do_req("or",       ALU_OR,  32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 0, 0, 0, 0, 0, SETTLE+1, 0, 0);
    do_req("illegal",  3'd5,    32'd1234,     32'd5678,     32'd0,        0, 0, 0, 1, 0, 0,        5, 0);
    do_req("early",    ALU_ADD, 32'd100,      32'd23,       32'd123,      0, 0, 0, 0, 0, SETTLE+1, 0, 1);

    // reset in the middle of DRIVE drops the transaction
    bus.req_op    = ALU_ADD;
    bus.req_a     = 32'd5;
    bus.req_b     = 32'd6;
    bus.req_valid = 1'b1;
    check("mid_rst_req_ready", 64'(bus.req_ready), 64'd1);
    tick();
    bus.req_valid = 1'b0;
    tick();
    tick();
    check("mid_rst_in_drive", 64'(dbg_state), 64'(ST_DRIVE));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_req_ready2", 64'(bus.req_ready), 64'd1);
    check("mid_rst_rsp_valid",  64'(bus.rsp_valid), 64'd0);
    check("mid_rst_alu_drv",    64'({bus.alu_a, bus.alu_b, bus.alu_op2, bus.alu_cin}), 64'd0);
    check("mid_rst_state",      64'(dbg_state), 64'(ST_IDLE));
    seen_rsp = 0;
    for (int i = 0; i < SETTLE + 3; i++) begin
      tick();
      if (bus.rsp_valid) seen_rsp++;
    end
    check("mid_rst_no_rsp", 64'(seen_rsp), 64'd0);

    do_req("add_after_rst", ALU_ADD, 32'h12345678, 32'h11111111, 32'h23456789, 0, 0, 0, 0, 0, SETTLE+1, 1, 0);

    // ---------------- final report ----------------
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
